// File: rtl/bch_syndrome_gen.sv
// BCH syndrome generator: serially accumulates r(alpha^j) for j = 1..2T by Horner's rule,
// then streams S1..S(2T) out one per handshake.
module bch_syndrome_gen #(
    parameter int unsigned         C_M         = 5,
    parameter int unsigned         C_N         = 31,
    parameter int unsigned         C_T         = 3,
    parameter logic [C_M-1:0]      C_POLY_PRIM = 5'h05
) (
    input  logic                            I_clk,
    input  logic                            I_rst,
    input  logic                            I_Bit,
    input  logic                            I_Bit_v,
    output logic                            O_Bit_rdy,
    output logic [C_M-1:0]                  O_Synd,
    output logic [$clog2(2*C_T+1)-1:0]      O_Synd_idx,
    output logic                            O_Synd_v,
    input  logic                            I_Synd_rdy,
    output logic                            O_Err
);

    localparam int unsigned NumSynd = 2 * C_T;
    localparam int unsigned IdxW    = $clog2(NumSynd + 1);
    localparam int unsigned CntW    = $clog2(C_N);

    typedef enum logic [0:0] {StAcc, StDump} state_e;

    // Multiply a field element by alpha (shift, reduce by the primitive polynomial).
    function automatic logic [C_M-1:0] gf_mul_alpha(input logic [C_M-1:0] x);
        logic [C_M-1:0] sh;
        sh = {x[C_M-2:0], 1'b0};
        return x[C_M-1] ? (sh ^ C_POLY_PRIM) : sh;
    endfunction

    // Multiply by alpha^p with p <= NumSynd; p is constant per call site.
    function automatic logic [C_M-1:0] gf_mul_alpha_pow(input logic [C_M-1:0] x,
                                                         input int unsigned p);
        logic [C_M-1:0] y;
        y = x;
        for (int unsigned i = 0; i < NumSynd; i++) begin
            if (i < p) y = gf_mul_alpha(y);
        end
        return y;
    endfunction

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                err_q, err_d;
    logic [C_M-1:0]      s_q [NumSynd];
    logic [C_M-1:0]      s_d [NumSynd];
    logic [C_M-1:0]      s_horner [NumSynd];
    logic                any_nonzero;

    // Horner step for every syndrome in parallel, and whether any result is nonzero.
    always_comb begin
        any_nonzero = 1'b0;
        for (int unsigned i = 0; i < NumSynd; i++) begin
            s_horner[i] = gf_mul_alpha_pow(s_q[i], i + 1) ^ {{(C_M-1){1'b0}}, I_Bit};
            any_nonzero = any_nonzero | (|s_horner[i]);
        end
    end

    // Next-state logic: accumulate bits in StAcc, walk the syndrome index in StDump.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        for (int unsigned i = 0; i < NumSynd; i++) s_d[i] = s_q[i];

        unique case (state_q)
            StAcc: begin
                if (I_Bit_v) begin
                    for (int unsigned i = 0; i < NumSynd; i++) s_d[i] = s_horner[i];
                    err_d = any_nonzero;
                    if (cnt_q == CntW'(C_N - 1)) begin
                        cnt_d   = '0;
                        state_d = StDump;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDump: begin
                if (I_Synd_rdy) begin
                    if (idx_q == IdxW'(NumSynd)) begin
                        idx_d   = IdxW'(1);
                        state_d = StAcc;
                        // Cleared so the next codeword starts its Horner chain from zero.
                        for (int unsigned i = 0; i < NumSynd; i++) s_d[i] = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StAcc;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= StAcc;
            cnt_q   <= '0;
            idx_q   <= IdxW'(1);
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NumSynd; i++) s_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < NumSynd; i++) s_q[i] <= s_d[i];
        end
    end

    // Outputs: handshakes from state, syndrome muxed from registers by the current index.
    always_comb begin
        O_Bit_rdy  = (state_q == StAcc);
        O_Synd_v   = (state_q == StDump);
        O_Synd_idx = idx_q;
        O_Err      = err_q;
        O_Synd     = '0;
        for (int unsigned i = 0; i < NumSynd; i++) begin
            if (idx_q == IdxW'(i + 1)) O_Synd = s_q[i];
        end
    end

endmodule

// File: tb/tb_bch_syndrome_gen.sv
// Directed bench for bch_syndrome_gen with default parameters (GF(32), N=31, T=3).
module tb_bch_syndrome_gen;

    logic       I_clk = 1'b0;
    logic       I_rst;
    logic       I_Bit;
    logic       I_Bit_v;
    logic       O_Bit_rdy;
    logic [4:0] O_Synd;
    logic [2:0] O_Synd_idx;
    logic       O_Synd_v;
    logic       I_Synd_rdy;
    logic       O_Err;

    int total = 0;
    int bad   = 0;

    bch_syndrome_gen dut (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_Bit      (I_Bit),
        .I_Bit_v    (I_Bit_v),
        .O_Bit_rdy  (O_Bit_rdy),
        .O_Synd     (O_Synd),
        .O_Synd_idx (O_Synd_idx),
        .O_Synd_v   (O_Synd_v),
        .I_Synd_rdy (I_Synd_rdy),
        .O_Err      (O_Err)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [30:0]     cw;     // cw[d] is the coefficient of x^d
        logic [5:0][4:0] synd;   // synd[j-1] is S_j
        logic            err;
        bit              gaps;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge I_clk);
        @(negedge I_clk);
    endtask

    // Send 31 bits highest degree first; optionally insert random idle cycles.
    task automatic send_word(input logic [30:0] cw, input bit gaps);
        for (int k = 0; k < 31; k++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) begin
                    I_Bit_v = 1'b0;
                    I_Bit   = 1'($urandom_range(0, 1));
                    step();
                end
            end
            I_Bit   = cw[30-k];
            I_Bit_v = 1'b1;
            step();
            I_Bit_v = 1'b0;
            if (k == 29) chk("synd_v_before_last_bit", 32'(O_Synd_v), 32'd0);
            if (k == 30) chk("synd_v_after_last_bit", 32'(O_Synd_v), 32'd1);
        end
    endtask

    // Collect syndromes first..6 with the consumer always ready.
    task automatic collect(input logic [5:0][4:0] synd, input logic err, input int first);
        I_Synd_rdy = 1'b1;
        for (int j = first; j <= 6; j++) begin
            chk("dump_valid", 32'(O_Synd_v), 32'd1);
            chk("dump_idx", 32'(O_Synd_idx), 32'(j));
            chk($sformatf("synd_S%0d", j), 32'(O_Synd), 32'(synd[j-1]));
            chk("dump_err", 32'(O_Err), 32'(err));
            chk("dump_bit_rdy", 32'(O_Bit_rdy), 32'd0);
            step();
        end
        chk("after_dump_valid", 32'(O_Synd_v), 32'd0);
        chk("after_dump_bit_rdy", 32'(O_Bit_rdy), 32'd1);
        chk("after_dump_idx", 32'(O_Synd_idx), 32'd1);
    endtask

    task automatic chk_reset_state();
        chk("rst_bit_rdy", 32'(O_Bit_rdy), 32'd1);
        chk("rst_synd_v", 32'(O_Synd_v), 32'd0);
        chk("rst_synd", 32'(O_Synd), 32'd0);
        chk("rst_idx", 32'(O_Synd_idx), 32'd1);
        chk("rst_err", 32'(O_Err), 32'd0);
    endtask

    initial begin
        // r(x)=0
        vecs[0].cw = 31'h0;
        vecs[0].synd = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        vecs[0].err = 1'b0; vecs[0].gaps = 1'b0;
        // r(x)=1
        vecs[1].cw = 31'h1;
        vecs[1].synd = {5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01};
        vecs[1].err = 1'b1; vecs[1].gaps = 1'b0;
        // r(x)=x: S_j = alpha^j
        vecs[2].cw = 31'h2;
        vecs[2].synd = {5'h0A, 5'h05, 5'h10, 5'h08, 5'h04, 5'h02};
        vecs[2].err = 1'b1; vecs[2].gaps = 1'b0;
        // x^7 * g(x), g = x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1, sent with gaps
        vecs[3].cw = 31'h0047_D780;
        vecs[3].synd = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        vecs[3].err = 1'b0; vecs[3].gaps = 1'b1;
        // r(x)=x^30: S_j = alpha^(30j)
        vecs[4].cw = 31'h4000_0000;
        vecs[4].synd = {5'h19, 5'h17, 5'h0B, 5'h16, 5'h09, 5'h12};
        vecs[4].err = 1'b1; vecs[4].gaps = 1'b1;

        I_rst = 1'b1; I_Bit = 1'b0; I_Bit_v = 1'b0; I_Synd_rdy = 1'b1;
        step();
        step();
        I_rst = 1'b0;
        chk_reset_state();

        for (int v = 0; v < 5; v++) begin
            send_word(vecs[v].cw, vecs[v].gaps);
            collect(vecs[v].synd, vecs[v].err, 1);
        end

        // Consumer stall at idx 3 while bits are offered: nothing moves, nothing consumed.
        send_word(vecs[2].cw, 1'b0);
        I_Synd_rdy = 1'b1;
        step();
        step();
        I_Synd_rdy = 1'b0;
        I_Bit_v    = 1'b1;
        I_Bit      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("stall_idx", 32'(O_Synd_idx), 32'd3);
            chk("stall_synd", 32'(O_Synd), 32'h08);
            chk("stall_valid", 32'(O_Synd_v), 32'd1);
            chk("stall_bit_rdy", 32'(O_Bit_rdy), 32'd0);
        end
        I_Bit_v = 1'b0;
        I_Bit   = 1'b0;
        collect(vecs[2].synd, 1'b1, 3);
        send_word(vecs[0].cw, 1'b0);
        collect(vecs[0].synd, 1'b0, 1);

        // Reset after 17 bits of a partial word, then a clean r(x)=x word.
        for (int k = 0; k < 17; k++) begin
            I_Bit   = 1'b1;
            I_Bit_v = 1'b1;
            step();
        end
        I_Bit_v = 1'b0;
        chk("partial_err_set", 32'(O_Err), 32'd1);
        I_rst = 1'b1;
        step();
        I_rst = 1'b0;
        chk_reset_state();
        send_word(vecs[2].cw, 1'b0);
        collect(vecs[2].synd, vecs[2].err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
